stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/button_debounce.sv | 48 ++++
 rtl/stopwatch_ctrl.sv | 113 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice: state encoding
// and the default button debounce interval.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_LAP     = 2'd3
  } state_t;

  // 10 ms at 100 MHz
  localparam int DEBOUNCE_DEFAULT = 1000000;
  localparam int DB_W_DEFAULT     = 20;

endpackage

// File: rtl/button_debounce.sv
// Conditions one raw push-button: two-flop synchronizer, stable-level debounce
// counter and a one-cycle press pulse on each accepted 0->1 change.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync;
  logic [DB_W-1:0] cnt;
  logic            level;
  logic            level_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], btn};
      level_d <= level;
      press   <= level & ~level_d;
      // The counter only advances while the synchronized level disagrees with
      // the accepted one; any return to agreement restarts the interval.
      if (sync[1] != level) begin
        if (cnt == LAST) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer for the 4-digit stopwatch datapath.
// Optional lap/display-hold support is built when STOPWATCH_CTRL_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int DB_W            = DB_W_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_clear,
  input  logic       wrap,
  output logic       run,
  output logic       clear,
  output logic       display_hold,
  output logic       lap_capture,
  output logic [1:0] state
);

  logic   ss_p;
  logic   lc_p;
  state_t state_q;
  state_t state_d;
  logic   clear_d;
  logic   lap_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_ss (
    .clock (clock),
    .reset (reset),
    .btn   (btn_start_stop),
    .press (ss_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_lc (
    .clock (clock),
    .reset (reset),
    .btn   (btn_lap_clear),
    .press (lc_p)
  );

  // clear/lap_capture are registered alongside the state so they coincide
  // with the first cycle of the new state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      clear       <= 1'b0;
      lap_capture <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear       <= clear_d;
      lap_capture <= lap_d;
    end
  end

  // Priority: wrap > ss_p > lc_p; losing events are dropped.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    lap_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_p)      state_d = ST_RUNNING;
        else if (lc_p) clear_d = 1'b1;
      end
      ST_RUNNING: begin
        if (wrap || ss_p) begin
          state_d = ST_PAUSED;
`ifdef STOPWATCH_CTRL_LAP_EN
        end else if (lc_p) begin
          state_d = ST_LAP;
          lap_d   = 1'b1;
`endif
        end
      end
      ST_PAUSED: begin
        if (ss_p) begin
          state_d = ST_RUNNING;
        end else if (lc_p) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
      end
`ifdef STOPWATCH_CTRL_LAP_EN
      ST_LAP: begin
        if (wrap || ss_p) state_d = ST_PAUSED;
        else if (lc_p)    state_d = ST_RUNNING;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run          = 1'b0;
    display_hold = 1'b0;
    case (state_q)
      ST_RUNNING: run = 1'b1;
`ifdef STOPWATCH_CTRL_LAP_EN
      ST_LAP: begin
        run          = 1'b1;
        display_hold = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4; exercises the lap
// path only when STOPWATCH_CTRL_LAP_EN is defined.
module tb_stopwatch_ctrl;

  logic       clock;
  logic       reset;
  logic       btn_start_stop;
  logic       btn_lap_clear;
  logic       wrap;
  logic       run;
  logic       clear;
  logic       display_hold;
  logic       lap_capture;
  logic [1:0] state;

  int checks;
  int errors;
  int clr_cnt;
  int lap_cnt;
  int trans_cnt;
  int clr_bad_state;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_lap_clear  (btn_lap_clear),
    .wrap           (wrap),
    .run            (run),
    .clear          (clear),
    .display_hold   (display_hold),
    .lap_capture    (lap_capture),
    .state          (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Holds the chosen buttons for len sampling edges, then releases them and
  // lets the release debounce; counts pulses and state changes meanwhile.
  task automatic push(input logic ss, input logic lc, input int len);
    logic [1:0] prev;
    clr_cnt       = 0;
    lap_cnt       = 0;
    trans_cnt     = 0;
    clr_bad_state = 0;
    prev          = state;
    btn_start_stop = ss;
    btn_lap_clear  = lc;
    for (int i = 0; i < len + 10; i++) begin
      @(negedge clock);
      if (clear) begin
        clr_cnt++;
        if (state != 2'd0) clr_bad_state++;
      end
      if (lap_capture) lap_cnt++;
      if (state != prev) trans_cnt++;
      prev = state;
      if (i == len - 1) begin
        btn_start_stop = 1'b0;
        btn_lap_clear  = 1'b0;
      end
    end
  endtask

  task automatic expect_state(input string name, input logic [1:0] exp_state, input logic exp_run);
    checks++;
    if (state !== exp_state) begin
      errors++;
      $display("FAIL %s state: got %0d expected %0d", name, state, exp_state);
    end
    checks++;
    if (run !== exp_run) begin
      errors++;
      $display("FAIL %s run: got %b expected %b", name, run, exp_run);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_start_stop = 1'b1;
    btn_lap_clear  = 1'b1;
    wrap = 1'b0;
    repeat (2) @(negedge clock);
    expect_state("reset", 2'd0, 1'b0);
    checks++;
    if ({clear, display_hold, lap_capture} !== 3'b000) begin
      errors++;
      $display("FAIL reset outputs: got clear/hold/lap=%b expected 000", {clear, display_hold, lap_capture});
    end
    reset = 1'b0;
    btn_start_stop = 1'b0;
    btn_lap_clear  = 1'b0;
    clr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (clear) clr_cnt++;
    end
    expect_state("post_reset", 2'd0, 1'b0);
    checks++;
    if (clr_cnt !== 0) begin
      errors++;
      $display("FAIL post_reset clear pulses: got %0d expected 0", clr_cnt);
    end
  endtask

  task automatic test_start_pause();
    btn_start_stop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (run !== (i >= 7)) begin
        errors++;
        $display("FAIL start_latency cycle %0d run: got %b expected %b", i, run, (i >= 7));
      end
      if (i == 9) btn_start_stop = 1'b0;
    end
    expect_state("started", 2'd1, 1'b1);
    repeat (8) @(negedge clock);
    push(1'b1, 1'b0, 6);
    expect_state("paused", 2'd2, 1'b0);
  endtask

  task automatic test_glitch_hold();
    push(1'b1, 1'b0, 3);
    expect_state("glitch", 2'd2, 1'b0);
    checks++;
    if (trans_cnt !== 0) begin
      errors++;
      $display("FAIL glitch transitions: got %0d expected 0", trans_cnt);
    end
    push(1'b1, 1'b0, 50);
    expect_state("hold50", 2'd1, 1'b1);
    checks++;
    if (trans_cnt !== 1) begin
      errors++;
      $display("FAIL hold50 transitions: got %0d expected 1", trans_cnt);
    end
  endtask

  task automatic test_clear();
    push(1'b1, 1'b0, 6);
    expect_state("pause_for_clear", 2'd2, 1'b0);
    for (int k = 0; k < 2; k++) begin
      push(1'b0, 1'b1, 6);
      expect_state("clear", 2'd0, 1'b0);
      checks++;
      if (clr_cnt !== 1) begin
        errors++;
        $display("FAIL clear pulse count (press %0d): got %0d expected 1", k, clr_cnt);
      end
      checks++;
      if (clr_bad_state !== 0) begin
        errors++;
        $display("FAIL clear coincident state (press %0d): got %0d non-idle cycles expected 0", k, clr_bad_state);
      end
    end
  endtask

  task automatic test_lap();
    push(1'b1, 1'b0, 6);
    expect_state("run_for_lap", 2'd1, 1'b1);
`ifdef STOPWATCH_CTRL_LAP_EN
    push(1'b0, 1'b1, 6);
    expect_state("lap", 2'd3, 1'b1);
    checks++;
    if (display_hold !== 1'b1 || lap_cnt !== 1) begin
      errors++;
      $display("FAIL lap entry: got hold=%b lap_pulses=%0d expected hold=1 lap_pulses=1", display_hold, lap_cnt);
    end
    push(1'b0, 1'b1, 6);
    expect_state("lap_exit", 2'd1, 1'b1);
    checks++;
    if (display_hold !== 1'b0 || lap_cnt !== 0) begin
      errors++;
      $display("FAIL lap exit: got hold=%b lap_pulses=%0d expected hold=0 lap_pulses=0", display_hold, lap_cnt);
    end
`else
    push(1'b0, 1'b1, 6);
    expect_state("lap_disabled", 2'd1, 1'b1);
    checks++;
    if (display_hold !== 1'b0 || lap_cnt !== 0) begin
      errors++;
      $display("FAIL lap disabled: got hold=%b lap_pulses=%0d expected hold=0 lap_pulses=0", display_hold, lap_cnt);
    end
`endif
  endtask

  task automatic test_simul_wrap();
    // Both presses land in the same cycle from RUNNING: ss_p wins.
    push(1'b1, 1'b1, 6);
    expect_state("simul", 2'd2, 1'b0);
    checks++;
    if (lap_cnt !== 0 || clr_cnt !== 0) begin
      errors++;
      $display("FAIL simul pulses: got lap=%0d clear=%0d expected 0 0", lap_cnt, clr_cnt);
    end
    // wrap while PAUSED is ignored
    wrap = 1'b1;
    @(negedge clock);
    wrap = 1'b0;
    @(negedge clock);
    expect_state("wrap_paused", 2'd2, 1'b0);
    // wrap alone while RUNNING pauses
    push(1'b1, 1'b0, 6);
    wrap = 1'b1;
    @(negedge clock);
    wrap = 1'b0;
    expect_state("wrap_running", 2'd2, 1'b0);
    push(1'b1, 1'b0, 6);
`ifdef STOPWATCH_CTRL_LAP_EN
    push(1'b0, 1'b1, 6);
    expect_state("lap_before_wrap", 2'd3, 1'b1);
`endif
    // wrap coincident with ss_p (press pulse in cycle 6 of the hold)
    btn_start_stop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 5) btn_start_stop = 1'b0;
      if (i == 6) wrap = 1'b1;
      if (i == 7) wrap = 1'b0;
    end
    expect_state("wrap_with_ss", 2'd2, 1'b0);
    checks++;
    if (display_hold !== 1'b0) begin
      errors++;
      $display("FAIL wrap_with_ss hold: got %b expected 0", display_hold);
    end
    repeat (10) @(negedge clock);
    expect_state("wrap_with_ss_settled", 2'd2, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_start_pause();
    test_glitch_hold();
    test_clear();
    test_lap();
    test_simul_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
